// File: rtl/aes_pkg.sv
// aes_pkg: AES-128 shared constants, GF(2^8) arithmetic, S-boxes and round helpers.
package aes_pkg;
    localparam int NR = 10;
    localparam int BLOCK = 128;
    localparam logic [7:0] RCON [0:NR] = '{8'h00, 8'h01, 8'h02, 8'h04, 8'h08, 8'h10,
                                           8'h20, 8'h40, 8'h80, 8'h1b, 8'h36};

    typedef enum logic [1:0] {IDLE, EXPAND, READY} key_state_e;

    function automatic logic [7:0] xtime(input logic [7:0] x);
        return {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p, x;
        p = '0;
        x = a;
        for (int i = 0; i < 8; i++) begin
            p = b[i] ? p ^ x : p;
            x = xtime(x);
        end
        return p;
    endfunction

    // Multiplicative inverse as a^254 via a short addition chain; maps 0 to 0.
    function automatic logic [7:0] gf_inv(input logic [7:0] a);
        logic [7:0] a2, a3, a12, a15, a240;
        a2 = gf_mul(a, a);
        a3 = gf_mul(a2, a);
        a12 = gf_mul(gf_mul(a3, a3), gf_mul(a3, a3));
        a15 = gf_mul(a12, a3);
        a240 = gf_mul(a15, a15);
        a240 = gf_mul(a240, a240);
        a240 = gf_mul(a240, a240);
        a240 = gf_mul(a240, a240);
        return gf_mul(gf_mul(a240, a12), a2);
    endfunction

    function automatic logic [7:0] rotl8(input logic [7:0] b, input int n);
        return (b << n) | (b >> (8 - n));
    endfunction

    function automatic logic [7:0] sbox(input logic [7:0] a);
        logic [7:0] b;
        b = gf_inv(a);
        return b ^ rotl8(b, 1) ^ rotl8(b, 2) ^ rotl8(b, 3) ^ rotl8(b, 4) ^ 8'h63;
    endfunction

    function automatic logic [7:0] inv_sbox(input logic [7:0] a);
        return gf_inv(rotl8(a, 1) ^ rotl8(a, 3) ^ rotl8(a, 6) ^ 8'h05);
    endfunction

    function automatic logic [BLOCK-1:0] next_round_key(input logic [BLOCK-1:0] k, input logic [7:0] rc);
        logic [31:0] t, w0, w1, w2, w3;
        t = {sbox(k[23:16]), sbox(k[15:8]), sbox(k[7:0]), sbox(k[31:24])} ^ {rc, 24'h0};
        w0 = k[127:96] ^ t;
        w1 = k[95:64] ^ w0;
        w2 = k[63:32] ^ w1;
        w3 = k[31:0] ^ w2;
        return {w0, w1, w2, w3};
    endfunction

    // Byte b of the state is row b%4, column b/4.
    function automatic logic [BLOCK-1:0] inv_shift_rows(input logic [BLOCK-1:0] s);
        logic [BLOCK-1:0] o;
        for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++)
                o[127-8*(4*c+r) -: 8] = s[127-8*(4*((c+4-r)%4)+r) -: 8];
        return o;
    endfunction

    function automatic logic [BLOCK-1:0] inv_sub_bytes(input logic [BLOCK-1:0] s);
        logic [BLOCK-1:0] o;
        for (int b = 0; b < 16; b++)
            o[127-8*b -: 8] = inv_sbox(s[127-8*b -: 8]);
        return o;
    endfunction

    function automatic logic [BLOCK-1:0] inv_mix_columns(input logic [BLOCK-1:0] s);
        logic [BLOCK-1:0] o;
        logic [7:0] a0, a1, a2, a3;
        for (int c = 0; c < 4; c++) begin
            {a0, a1, a2, a3} = s[127-32*c -: 32];
            o[127-32*c -: 32] = {
                gf_mul(a0, 8'h0e) ^ gf_mul(a1, 8'h0b) ^ gf_mul(a2, 8'h0d) ^ gf_mul(a3, 8'h09),
                gf_mul(a0, 8'h09) ^ gf_mul(a1, 8'h0e) ^ gf_mul(a2, 8'h0b) ^ gf_mul(a3, 8'h0d),
                gf_mul(a0, 8'h0d) ^ gf_mul(a1, 8'h09) ^ gf_mul(a2, 8'h0e) ^ gf_mul(a3, 8'h0b),
                gf_mul(a0, 8'h0b) ^ gf_mul(a1, 8'h0d) ^ gf_mul(a2, 8'h09) ^ gf_mul(a3, 8'h0e)};
        end
        return o;
    endfunction
endpackage

// File: rtl/aes_inv_round.sv
// aes_inv_round: one registered middle decryption round with its valid flop.
module aes_inv_round
    import aes_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             in_valid,
    input  logic [BLOCK-1:0] din,
    input  logic [BLOCK-1:0] rk,
    output logic             out_valid,
    output logic [BLOCK-1:0] dout
);
    logic load;
    assign load = in_valid & ~flush;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            out_valid <= 1'b0;
            dout <= '0;
        end else begin
            out_valid <= load;
            if (load) dout <= inv_mix_columns(inv_sub_bytes(inv_shift_rows(din)) ^ rk);
        end
    end
endmodule

// File: rtl/aes_dec_pipe.sv
// aes_dec_pipe: AES-128 decryption pipeline, one block per cycle, with an
// iterative key expander that must finish before blocks are accepted.
module aes_dec_pipe
    import aes_pkg::*;
#(
    parameter int BLOCK_LENGTH = BLOCK
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    key_load,
    input  logic [BLOCK_LENGTH-1:0] KEY,
    input  logic                    in_valid,
    input  logic [BLOCK_LENGTH-1:0] IN,
    output logic                    key_ready,
    output logic                    in_ready,
    output logic                    out_valid,
    output logic [BLOCK_LENGTH-1:0] OUT
);
    key_state_e state;
    logic [3:0] cnt;
    logic [BLOCK-1:0] rk [0:NR];
    logic iv, v0, acc;
    logic [BLOCK-1:0] id, d0;
    logic pv [0:NR-1];
    logic [BLOCK-1:0] pd [0:NR-1];

    assign in_ready = key_ready;
    assign acc = in_valid & in_ready & ~key_load;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
            cnt <= '0;
            key_ready <= 1'b0;
            for (int i = 0; i <= NR; i++) rk[i] <= '0;
        end else if (key_load) begin
            state <= EXPAND;
            cnt <= 4'd1;
            key_ready <= 1'b0;
            rk[0] <= KEY;
        end else if (state == EXPAND) begin
            rk[cnt] <= next_round_key(rk[cnt-4'd1], RCON[cnt]);
            cnt <= (cnt == 4'(NR)) ? cnt : cnt + 4'd1;
            state <= (cnt == 4'(NR)) ? READY : EXPAND;
            key_ready <= (cnt == 4'(NR));
        end
    end

    // Input capture, stage 0 and stage 10; key_load kills every valid bit.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            iv <= 1'b0;
            id <= '0;
            v0 <= 1'b0;
            d0 <= '0;
            out_valid <= 1'b0;
            OUT <= '0;
        end else begin
            iv <= acc;
            v0 <= iv & ~key_load;
            out_valid <= pv[NR-1] & ~key_load;
            if (acc) id <= IN;
            if (iv & ~key_load) d0 <= id ^ rk[NR];
            if (pv[NR-1] & ~key_load) OUT <= inv_sub_bytes(inv_shift_rows(pd[NR-1])) ^ rk[0];
        end
    end

    assign pv[0] = v0;
    assign pd[0] = d0;

    for (genvar i = 1; i < NR; i++) begin : g
        aes_inv_round u_rnd (
            .clk(clk),
            .rst(rst),
            .flush(key_load),
            .in_valid(pv[i-1]),
            .din(pd[i-1]),
            .rk(rk[NR-i]),
            .out_valid(pv[i]),
            .dout(pd[i])
        );
    end
endmodule

// File: doc/aes_dec_pipe.md
AES_DEC_PIPE -- requirements
Module: aes_dec_pipe

Interface
REQ-001 SHALL have parameter BLOCK_LENGTH, default 128, meaning the block width in bits; only the value 128 is supported.
REQ-002 SHALL have port clk, input, 1 bit: the single clock; all state is updated on its rising edge.
REQ-003 SHALL have port rst, input, 1 bit: asynchronous active-low reset.
REQ-004 SHALL have port key_load, input, 1 bit: single-cycle pulse that starts key expansion of KEY.
REQ-005 SHALL have port KEY, input, 128 bits: cipher key, sampled only when key_load=1.
REQ-006 SHALL have port in_valid, input, 1 bit: a ciphertext block is present on IN.
REQ-007 SHALL have port IN, input, 128 bits: ciphertext block, byte 0 in bits [127:120].
REQ-008 SHALL have port key_ready, output, 1 bit: all 11 round keys are valid.
REQ-009 SHALL have port in_ready, output, 1 bit: equal to key_ready.
REQ-010 SHALL have port out_valid, output, 1 bit: OUT holds a plaintext block this cycle.
REQ-011 SHALL have port OUT, output, 128 bits: plaintext block.

Function
REQ-012 Key FSM SHALL have three states: IDLE, EXPAND and READY.
REQ-013 A key_load in any state SHALL capture KEY as k0, clear key_ready, go to EXPAND and set the round counter to 1.
REQ-014 EXPAND SHALL compute one FIPS-197 round key per cycle (k1..k10, with Rcon indexed by the counter) and go to READY on the edge that writes k10, i.e. the 10th edge after the key_load edge.
REQ-015 key_ready SHALL be 1 exactly in READY.
REQ-016 A block SHALL be accepted on an edge where in_valid=1 and in_ready=1; in_valid while in_ready=0 SHALL be ignored (no stall, no buffering).
REQ-017 The datapath SHALL be an 11-stage registered pipeline:
- stage 0: AddRoundKey k10.
- stage i (1..9): InvShiftRows, InvSubBytes, AddRoundKey k(10-i), InvMixColumns.
- stage 10: InvShiftRows, InvSubBytes, AddRoundKey k0.
REQ-018 A valid bit SHALL travel with each block; latency SHALL be 11 cycles (accept edge N gives out_valid=1 after edge N+11); throughput SHALL be one block per cycle.
REQ-019 A stage register SHALL load only when its incoming valid bit is 1; OUT SHALL hold its last value while out_valid=0.
REQ-020 key_load SHALL flush the pipeline: all valid bits clear on the same edge, and in-flight blocks are discarded with no out_valid for them.
REQ-021 key_load and in_valid on the same edge SHALL discard the block, because in_ready drops the next cycle and the flush takes priority.
REQ-022 A key_load arriving during EXPAND SHALL restart expansion from the new KEY.

Reset
REQ-023 While rst=0 the block SHALL force: FSM=IDLE, counter=0, all round keys=0, all valid bits=0, all stage data=0, key_ready=0, in_ready=0, out_valid=0, OUT=0.
REQ-024 Reset assertion mid-expansion or mid-stream SHALL discard all state; after release a new key_load is required.

Structure
REQ-025 A shared package aes_pkg SHALL hold the S-box and inverse S-box functions, the Rcon table, the xtime/GF(2^8) multiply functions and the constants NR=10 and BLOCK=128, shared with the encryption path.
REQ-026 Stages 1..9 SHALL be instances of one sub-module, aes_inv_round (combinational logic plus an output register and valid flop); stages 0 and 10 SHALL be inline.

Verification
REQ-027 FIPS-197 C.1: key_load with KEY=000102030405060708090a0b0c0d0e0f, wait for key_ready, IN=69c4e0d86a7b0430d8cdb78070b4c55a -> 11 cycles later out_valid=1 and OUT=00112233445566778899aabbccddeeff.
REQ-028 FIPS-197 App. B: KEY=2b7e151628aed2a6abf7158809cf4f3c, IN=3925841d02dc09fbdc118597196a0b32 -> OUT=3243f6a8885a308d313198a2e0370734.
REQ-029 Key timing: key_load at edge 0 -> key_ready=0 through edge 9 and =1 after edge 10; k10 for C.1 = 13111d7fe3944a17f307a78b4d2b30c5.
REQ-030 Back-to-back: 12 consecutive C.1/App. B blocks alternating -> 12 consecutive out_valid cycles with correct plaintexts in order.
REQ-031 Flush: key_load 5 cycles after accepting 3 blocks -> no out_valid for them; a block sent after key_ready decrypts under the new key.
REQ-032 Reset: rst=0 mid-stream -> all outputs 0 immediately; in_valid after release with no key_load -> no out_valid.
